// File: rtl/pulse_meter.sv
// Pulse width meter: synchronises an async input and reports its high time in
// prescaled ticks. Define PULSE_METER_GLITCH_EN to drop results shorter than MIN_TICKS.
//
// state   | meaning
// IDLE    | waiting for a rise on the synchronised input
// MEASURE | pulse high; prescaler and tick counter running
// REPORT  | one cycle: publish (or discard) the result
module pulse_meter #(
  parameter int PRESCALE  = 1000,
  parameter int WIDTH     = 8,
  parameter int MIN_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] width,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TICK_MAX = '1;
  localparam logic [WIDTH-1:0] TICK_PRE = TICK_MAX - 1'b1;
  localparam logic [WIDTH-1:0] MIN_T    = WIDTH'(MIN_TICKS);
`ifdef PULSE_METER_GLITCH_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  state_t           state, next_state;
  logic             sync1, sync2, hist;
  logic             live, armed;
  logic [PW-1:0]    psc;
  logic [WIDTH-1:0] ticks;
  logic             sat;
  logic             rise, fall;
  logic             clear_cnt, report_ok, accept;

  // armed needs one real low sample after reset, so a pulse already high
  // at reset release is never mistaken for a fresh rise.
  assign rise   = sync2 & ~hist & armed;
  assign fall   = ~sync2 & hist;
  assign accept = !GLITCH_EN || (ticks >= MIN_T);
  assign busy   = (state == MEASURE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      hist     <= 1'b0;
      live     <= 1'b0;
      armed    <= 1'b0;
      psc      <= '0;
      ticks    <= '0;
      sat      <= 1'b0;
      width    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      hist  <= sync2;
      live  <= 1'b1;
      if (live && !sync1) armed <= 1'b1;
      state <= next_state;
      valid <= report_ok;
      if (report_ok) begin
        width    <= ticks;
        overflow <= sat;
      end
      if (clear_cnt) begin
        psc   <= '0;
        ticks <= '0;
        sat   <= 1'b0;
      end else if (state == MEASURE) begin
        // the fall cycle still counts, so N high cycles give N increments
        if (psc == PSC_LAST) begin
          psc <= '0;
          if (ticks != TICK_MAX) ticks <= ticks + 1'b1;
          if (ticks == TICK_PRE) sat <= 1'b1;
        end else begin
          psc <= psc + 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    clear_cnt  = 1'b0;
    report_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = MEASURE;
          clear_cnt  = 1'b1;
        end
      end
      MEASURE: begin
        if (fall) next_state = REPORT;
      end
      REPORT: begin
        report_ok = accept;
        clear_cnt = rise;
        next_state = rise ? MEASURE : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
